// File: rtl/key_sw_input.sv
// key_sw_input: pushbutton / slide-switch input block with Avalon-MM slave.
//
// Each of the 4 keys and 10 switches is synchronized (SYNC_STAGES flops),
// debounced (DEBOUNCE_CYCLES stable cycles) and exposed through a 4-word
// register map with an edge-capture register, an interrupt mask and a level irq.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          synchronous, active-high
//   key_n[3:0]     raw pushbuttons, asynchronous, active-low
//   sw[9:0]        raw slide switches, asynchronous, active-high
//   avs_*          Avalon-MM slave (addr 0 KEYS, 1 SWITCHES, 2 EDGE W1C, 3 MASK)
//   irq            level interrupt, OR of EDGE & MASK (registered)
//   key_pressed    debounced key state, 1 = pressed
//
// Build option: define KEY_SW_SW_EDGE_EN to add switch edge capture
// (EDGE[13:4], MASK[13:4]); without it those bits read 0 and have no logic.

// One synchronizer + debouncer lane. The lane works on the logical level
// (1 = asserted), so active-low inputs are inverted after synchronization.
module key_sw_lane #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_i,
    output logic stable_o,
    output logic chg_o       // stable value changes at the coming edge
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   stable_q, stable_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    assign synced = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (synced != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = synced;
            else                                    cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // Reset to the idle raw level so a held input starts a fresh debounce.
            sync_q   <= {SYNC_STAGES{ACTIVE_LOW}};
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
    assign chg_o    = stable_d ^ stable_q;
endmodule

module key_sw_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_n,
    input  logic [9:0]  sw,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq,
    output logic [3:0]  key_pressed
);
    localparam int NK = 4;
    localparam int NI = 14;

    logic [NI-1:0] raw, stable, chg;
    assign raw = {sw, key_n};

    for (genvar i = 0; i < NI; i++) begin : g_lane
        key_sw_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES),
            .ACTIVE_LOW     ((i < NK) ? 1'b1 : 1'b0)
        ) u_lane (
            .clk_i   (clk),
            .reset_i (reset),
            .raw_i   (raw[i]),
            .stable_o(stable[i]),
            .chg_o   (chg[i])
        );
    end

    logic wr_edge, wr_mask;
    assign wr_edge = avs_write && (avs_address == 2'd2);
    assign wr_mask = avs_write && (avs_address == 2'd3);

    // Key edges capture presses only: a change while stable is 0 is a 0->1.
    logic [3:0] key_edge_q, key_edge_d, key_mask_q, key_mask_d;
    always_comb begin
        key_edge_d = key_edge_q;
        if (wr_edge) key_edge_d = key_edge_d & ~avs_writedata[3:0];
        key_edge_d = key_edge_d | (chg[3:0] & ~stable[3:0]);   // set beats clear
        key_mask_d = wr_mask ? avs_writedata[3:0] : key_mask_q;
    end

    logic [13:0] edge_w, mask_w;
`ifdef KEY_SW_SW_EDGE_EN
    logic [9:0] sw_edge_q, sw_edge_d, sw_mask_q, sw_mask_d;
    always_comb begin
        sw_edge_d = sw_edge_q;
        if (wr_edge) sw_edge_d = sw_edge_d & ~avs_writedata[13:4];
        sw_edge_d = sw_edge_d | chg[13:4];                      // either direction
        sw_mask_d = wr_mask ? avs_writedata[13:4] : sw_mask_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_edge_q <= '0;
            sw_mask_q <= '0;
        end else begin
            sw_edge_q <= sw_edge_d;
            sw_mask_q <= sw_mask_d;
        end
    end
    assign edge_w = {sw_edge_q, key_edge_q};
    assign mask_w = {sw_mask_q, key_mask_q};
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[31:14];
`else
    assign edge_w = {10'b0, key_edge_q};
    assign mask_w = {10'b0, key_mask_q};
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[31:4];
`endif

    // Read mux sees pre-write register values, so read+write returns old data.
    logic [31:0] rdata_d;
    always_comb begin
        rdata_d = '0;
        if (avs_read) begin
            case (avs_address)
                2'd0: rdata_d = {28'b0, stable[3:0]};
                2'd1: rdata_d = {22'b0, stable[13:4]};
                2'd2: rdata_d = {18'b0, edge_w};
                default: rdata_d = {18'b0, mask_w};
            endcase
        end
    end

    logic [31:0] rdata_q;
    logic        irq_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            key_edge_q <= '0;
            key_mask_q <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            key_edge_q <= key_edge_d;
            key_mask_q <= key_mask_d;
            rdata_q    <= rdata_d;
            irq_q      <= |(edge_w & mask_w);
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;
    assign key_pressed  = stable[3:0];
endmodule

// File: tb/tb_key_sw_input.sv
module tb_key_sw_input;
  localparam int DEB = 4;
  localparam int SYN = 2;
  localparam int NH  = SYN + DEB - 1;
`ifdef KEY_SW_SW_EDGE_EN
  localparam bit SWEN = 1'b1;
`else
  localparam bit SWEN = 1'b0;
`endif
  localparam logic [13:0] MASKW = SWEN ? 14'h3fff : 14'h000f;

  logic        clk, reset;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic [1:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        irq;
  logic [3:0]  key_pressed;

  key_sw_input #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYN)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw(sw),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq), .key_pressed(key_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a level is accepted once the last DEB synchronized
  // samples (SYN cycles old) all disagree with the current stable level.
  logic [13:0] h [NH];
  logic [13:0] m_st = '0, m_edge = '0, m_mask = '0;
  logic [31:0] m_rd = '0;
  logic        m_irq = 1'b0;

  function automatic logic [31:0] reg_val(input logic [1:0] a);
    case (a)
      2'd0: return {28'b0, m_st[3:0]};
      2'd1: return {22'b0, m_st[13:4]};
      2'd2: return {18'b0, m_edge};
      default: return {18'b0, m_mask};
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [13:0] smp, nst, set, clr;
    logic flip;
    smp = {sw, ~key_n};
    if (reset) begin
      for (int k = 0; k < NH; k++) h[k] = '0;
      m_st = '0; m_edge = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
    end else begin
      m_irq = |(m_edge & m_mask);
      m_rd  = avs_read ? reg_val(avs_address) : 32'd0;
      for (int i = 0; i < 14; i++) begin
        flip = 1'b1;
        for (int k = SYN - 1; k < NH; k++) if (h[k][i] == m_st[i]) flip = 1'b0;
        nst[i] = flip ? ~m_st[i] : m_st[i];
      end
      set = {SWEN ? (nst[13:4] ^ m_st[13:4]) : 10'd0, nst[3:0] & ~m_st[3:0]};
      clr = (avs_write && avs_address == 2'd2) ? avs_writedata[13:0] : 14'd0;
      m_edge = (m_edge & ~clr) | set;
      if (avs_write && avs_address == 2'd3) m_mask = avs_writedata[13:0] & MASKW;
      m_st = nst;
      for (int k = NH - 1; k > 0; k--) h[k] = h[k-1];
      h[0] = smp;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("key_pressed", {28'b0, key_pressed}, {28'b0, m_st[3:0]});
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
    chk("readdata", avs_readdata, m_rd);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_read = 1'b1; avs_address = a;
    tick();
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  logic [31:0] d;
  int b;

  initial begin
    reset = 1'b1; key_n = 4'hf; sw = '0; avs_address = '0;
    avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    ticks(3);
    chk("reset_kp", {28'b0, key_pressed}, 32'd0);
    chk("reset_irq", {31'b0, irq}, 32'd0);
    chk("reset_rd", avs_readdata, 32'd0);
    reset = 1'b0;
    ticks(2);

    // key0 press accepted exactly SYN+DEB cycles after the raw edge
    key_n[0] = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) chk("press_lat_early", {31'b0, key_pressed[0]}, 32'd0);
      if (i == 6) chk("press_lat", {31'b0, key_pressed[0]}, 32'd1);
    end
    rd(2'd2, d); chk("edge_key0", d, 32'h1);
    key_n[0] = 1'b1; ticks(7);
    rd(2'd2, d); chk("release_no_edge", d, 32'h1);
    wr(2'd2, 32'h3fff);

    // short glitch on key1 is rejected
    key_n[1] = 1'b0; ticks(3); key_n[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("glitch_kp", {28'b0, key_pressed}, 32'd0);
    end
    rd(2'd2, d); chk("glitch_edge", d, 32'h0);

    // irq follows EDGE&MASK one cycle later; W1C drops it
    wr(2'd3, 32'h1);
    key_n[0] = 1'b0; ticks(6);
    chk("irq_lag", {31'b0, irq}, 32'd0);
    tick(); chk("irq_set", {31'b0, irq}, 32'd1);
    wr(2'd2, 32'h1);
    tick(); chk("irq_clr", {31'b0, irq}, 32'd0);
    key_n[0] = 1'b1; ticks(7);

    // clear and set of EDGE[2] in the same cycle: set wins
    key_n[2] = 1'b0; ticks(5);
    wr(2'd2, 32'h4);
    rd(2'd2, d); chk("set_wins", d & 32'h4, 32'h4);
    key_n[2] = 1'b1; ticks(7);
    wr(2'd2, 32'h3fff);

    // switch edge capture (config dependent)
    wr(2'd3, 32'h10);
    sw[0] = 1'b1; ticks(7);
    rd(2'd2, d); chk("sw_edge", d, SWEN ? 32'h10 : 32'h0);
    chk("sw_irq", {31'b0, irq}, {31'b0, SWEN});
    rd(2'd1, d); chk("sw_val", d, 32'h1);
    rd(2'd3, d); chk("mask_rd", d, SWEN ? 32'h10 : 32'h0);
    wr(2'd2, 32'h3fff);

    // reset mid-debounce discards the count
    key_n[3] = 1'b0; ticks(2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_mid_kp", {28'b0, key_pressed}, 32'd0);
    chk("rst_mid_irq", {31'b0, irq}, 32'd0);
    chk("rst_mid_rd", avs_readdata, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) chk("rst_lat_early", {31'b0, key_pressed[3]}, 32'd0);
      if (i == 6) chk("rst_lat", {31'b0, key_pressed[3]}, 32'd1);
    end
    key_n[3] = 1'b1; ticks(7);

    // simultaneous read+write returns pre-write value
    wr(2'd3, 32'h3);
    avs_read = 1'b1; avs_write = 1'b1; avs_address = 2'd3; avs_writedata = 32'h5;
    tick();
    avs_read = 1'b0; avs_write = 1'b0;
    chk("rw_old", avs_readdata, 32'h3);
    rd(2'd3, d); chk("rw_new", d, 32'h5);
    rd(2'd0, d); chk("keys_wr_ign", d, 32'h0);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) begin
        b = $urandom_range(13);
        if (b < 4) key_n[b] = ~key_n[b];
        else       sw[b-4]  = ~sw[b-4];
      end
      avs_read      = ($urandom_range(2) == 0);
      avs_write     = ($urandom_range(5) == 0);
      avs_address   = 2'($urandom_range(3));
      avs_writedata = $urandom;
      tick();
    end
    avs_read = 1'b0; avs_write = 1'b0;
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
